// File: rtl/seq_gen_1001_if.sv
// Control and serial-bit handshake bundle for seq_gen_1001.
// master = the side that issues start and consumes bits; slave = the generator.
interface seq_gen_1001_if #(
  parameter int CNT_W = 8,
  parameter int GAP_W = 4
);
  logic             start;
  logic [CNT_W-1:0] num_frames;
  logic [GAP_W-1:0] gap_len;
  logic             out_ready;
  logic             out_bit;
  logic             out_valid;
  logic             frame_end;
  logic             busy;
  logic             done;

  modport master (
    output start, num_frames, gap_len, out_ready,
    input  out_bit, out_valid, frame_end, busy, done
  );

  modport slave (
    input  start, num_frames, gap_len, out_ready,
    output out_bit, out_valid, frame_end, busy, done
  );
endinterface

// File: rtl/seq_gen_1001.sv
// Serialises N "1001" frames separated by G zero bits onto a valid/ready bit stream.
// Moore FSM: every output decodes from the registered state only.
module seq_gen_1001 #(
  parameter int CNT_W = 8,
  parameter int GAP_W = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  seq_gen_1001_if.slave        bus,
  output logic [2:0]           state_dbg
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    S1A  = 3'd1,
    S0A  = 3'd2,
    S0B  = 3'd3,
    S1B  = 3'd4,
    GAP  = 3'd5,
    DONE = 3'd6
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] frames_left_q, frames_left_d;
  logic [GAP_W-1:0] gap_cfg_q, gap_cfg_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic             xfer;

  // Bit side: a bit moves only in a cycle where out_valid and out_ready are both 1;
  // out_valid never waits on out_ready, and while stalled every output holds.
  assign xfer      = bus.out_valid & bus.out_ready;
  assign state_dbg = state_q;

  always_comb begin
    bus.out_bit   = 1'b0;
    bus.out_valid = 1'b0;
    bus.frame_end = 1'b0;
    bus.done      = 1'b0;
    bus.busy      = (state_q != IDLE);
    case (state_q)
      S1A:     begin bus.out_bit = 1'b1; bus.out_valid = 1'b1; end
      S0A,
      S0B,
      GAP:     bus.out_valid = 1'b1;
      S1B:     begin bus.out_bit = 1'b1; bus.out_valid = 1'b1; bus.frame_end = 1'b1; end
      DONE:    bus.done = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    frames_left_d = frames_left_q;
    gap_cfg_d     = gap_cfg_q;
    gap_cnt_d     = gap_cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          frames_left_d = bus.num_frames;
          gap_cfg_d     = bus.gap_len;
          state_d       = (bus.num_frames == '0) ? DONE : S1A;
        end
      end
      S1A: if (xfer) state_d = S0A;
      S0A: if (xfer) state_d = S0B;
      S0B: if (xfer) state_d = S1B;
      S1B: begin
        if (xfer) begin
          frames_left_d = frames_left_q - 1'b1;
          if (frames_left_q == CNT_W'(1)) begin
            state_d = DONE;
          end else if (gap_cfg_q == '0) begin
            state_d = S1A;
          end else begin
            gap_cnt_d = gap_cfg_q;
            state_d   = GAP;
          end
        end
      end
      GAP: begin
        if (xfer) begin
          gap_cnt_d = gap_cnt_q - 1'b1;
          if (gap_cnt_q == GAP_W'(1)) state_d = S1A;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= IDLE;
      frames_left_q <= '0;
      gap_cfg_q     <= '0;
      gap_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      frames_left_q <= frames_left_d;
      gap_cfg_q     <= gap_cfg_d;
      gap_cnt_q     <= gap_cnt_d;
    end
  end

endmodule

// File: tb/tb_seq_gen_1001.sv
// Bench for seq_gen_1001: expected bit stream built from frame/gap rules, checked each cycle.
module tb_seq_gen_1001;

  logic       clk;
  logic       reset;
  logic [2:0] state_dbg;
  int         errors;
  int         checks;
  logic [1:0] exp_q[$];   // {frame_end, bit} per expected transfer
  logic [4:0] out_word;

  seq_gen_1001_if #(.CNT_W(8), .GAP_W(4)) bus ();

  seq_gen_1001 #(.CNT_W(8), .GAP_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .state_dbg (state_dbg)
  );

  assign out_word = {bus.busy, bus.done, bus.frame_end, bus.out_valid, bus.out_bit};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Caller sits just after a negedge in an IDLE cycle; that cycle becomes cycle k.
  task automatic run_burst(input int n, input int g, input bit use_mask,
                           input logic [63:0] stall_mask, input bit poke);
    int cyc;
    int stalls;
    int bits;
    bit rdy;
    exp_q.delete();
    for (int f = 0; f < n; f++) begin
      exp_q.push_back(2'b01);
      exp_q.push_back(2'b00);
      exp_q.push_back(2'b00);
      exp_q.push_back(2'b11);
      if (f < n - 1)
        for (int z = 0; z < g; z++) exp_q.push_back(2'b00);
    end
    bits = (n == 0) ? 0 : 4 * n + (n - 1) * g;
    check("idle_before", {27'd0, out_word}, 32'd0);
    bus.start      = 1'b1;
    bus.num_frames = 8'(n);
    bus.gap_len    = 4'(g);
    bus.out_ready  = 1'b1;
    cyc    = 0;
    stalls = 0;
    forever begin
      @(negedge clk);
      cyc++;
      bus.start = poke && (cyc == 6);
      if (cyc > 20000) begin
        check("timeout", 32'd1, 32'd0);
        break;
      end
      if (exp_q.size() != 0) begin
        check("valid", {31'd0, bus.out_valid}, 32'd1);
        check("bit", {31'd0, bus.out_bit}, {31'd0, exp_q[0][0]});
        check("frame_end", {31'd0, bus.frame_end}, {31'd0, exp_q[0][1]});
        check("busy", {31'd0, bus.busy}, 32'd1);
        check("done_early", {31'd0, bus.done}, 32'd0);
        rdy = use_mask ? !stall_mask[cyc] : ($urandom_range(0, 3) != 0);
        bus.out_ready = rdy;
        if (rdy) void'(exp_q.pop_front());
        else stalls++;
      end else begin
        check("done", {31'd0, bus.done}, 32'd1);
        check("busy_done", {31'd0, bus.busy}, 32'd1);
        check("valid_done", {31'd0, bus.out_valid}, 32'd0);
        check("done_cycle", cyc, 1 + bits + stalls);
        bus.start     = poke;  // a start during DONE must be ignored
        bus.out_ready = 1'b1;
        break;
      end
    end
    @(negedge clk);
    bus.start = 1'b0;
    check("idle_after", {27'd0, out_word}, 32'd0);
  endtask

  initial begin
    errors         = 0;
    checks         = 0;
    reset          = 1'b0;
    bus.start      = 1'b1;
    bus.num_frames = 8'd3;
    bus.gap_len    = 4'd1;
    bus.out_ready  = 1'b1;

    // Reset held two cycles with start asserted.
    repeat (2) begin
      @(negedge clk);
      check("rst_outs", {27'd0, out_word}, 32'd0);
    end
    reset     = 1'b1;
    bus.start = 1'b0;
    @(negedge clk);
    check("rst_release", {27'd0, out_word}, 32'd0);

    run_burst(1, 3, 1'b1, 64'h0, 1'b0);    // single frame
    run_burst(3, 2, 1'b1, 64'h0, 1'b1);    // gaps, ignored start at k+6 and in DONE
    run_burst(2, 0, 1'b1, 64'h0, 1'b0);    // back-to-back
    run_burst(2, 1, 1'b1, 64'h8C, 1'b0);   // stalls in k+2, k+3, k+7
    run_burst(0, 5, 1'b1, 64'h0, 1'b0);    // empty burst
    run_burst(2, 15, 1'b1, 64'h0, 1'b0);   // maximum gap

    // Reset in cycle k+3 of an N=2, G=1 burst.
    bus.start      = 1'b1;
    bus.num_frames = 8'd2;
    bus.gap_len    = 4'd1;
    bus.out_ready  = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      check("pre_rst_valid", {31'd0, bus.out_valid}, 32'd1);
      check("pre_rst_bit", {31'd0, bus.out_bit}, (c == 1) ? 32'd1 : 32'd0);
    end
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_outs", {27'd0, out_word}, 32'd0);
    reset = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("post_rst_outs", {27'd0, out_word}, 32'd0);
    end

    run_burst(1, 0, 1'b0, 64'h0, 1'b0);
    for (int i = 0; i < 14; i++)
      run_burst($urandom_range(0, 6), $urandom_range(0, 5), 1'b0, 64'h0, 1'($urandom_range(0, 1)));
    run_burst(255, 15, 1'b0, 64'h0, 1'b0); // maximum burst under random backpressure

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_gen_1001.md
# seq_gen_1001

Pattern transmitter that serialises a programmable number of "1001" frames onto a single-bit stream, one bit per accepted transfer, with a programmable run of '0' gap bits between frames. It is the stimulus/transmit end of the 1001 sequence-detection path: its `out_bit` stream feeds a 1001 sequence detector's `inp_bit` input. A start/busy/done handshake sits on the control side and a valid/ready handshake on the bit side. Tie `out_ready` high when the sink consumes one bit per clock.

## Interface
- `CNT_W`, default 8: width of the frame-count input.
- `GAP_W`, default 4: width of the gap-length input.

- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-low; 0 = reset.
- `start`  in  1  begin a burst; accepted only when `busy`=0.
- `num_frames`  in  CNT_W  frames in the burst; sampled on the accepted `start`.
- `gap_len`  in  GAP_W  '0' bits between consecutive frames; sampled on the accepted `start`.
- `out_ready`  in  1  sink accepts `out_bit` this cycle.
- `out_bit`  out  1  current serial bit.
- `out_valid`  out  1  `out_bit` is meaningful.
- `frame_end`  out  1  high while the final '1' of a frame is presented.
- `busy`  out  1  burst in progress, including the DONE cycle.
- `done`  out  1  one-cycle pulse after the last bit is transferred.

## Operation
- Moore FSM with states IDLE, S1A, S0A, S0B, S1B, GAP, DONE. All outputs decode from registered state, so none depends combinationally on `out_ready`.
- Per-state outputs:
  - S1A: `out_bit`=1, `out_valid`=1.
  - S0A and S0B: `out_bit`=0, `out_valid`=1.
  - S1B: `out_bit`=1, `out_valid`=1, `frame_end`=1.
  - GAP: `out_bit`=0, `out_valid`=1.
  - DONE: `done`=1.
  - IDLE: all outputs 0.
  - `busy` = (state != IDLE).
- A transfer is a cycle with `out_valid`=1 and `out_ready`=1. States S1A..GAP advance only on a transfer; otherwise state and all outputs hold.
- IDLE:
  - `start`=1 latches `num_frames` into the frame counter `frames_left` and `gap_len` into `gap_cfg`.
  - If `num_frames`=0, go to DONE; otherwise go to S1A.
- Frame sequence: S1A -> S0A -> S0B -> S1B.
- S1B on transfer:
  - Decrement `frames_left`.
  - If `frames_left` was 1, go to DONE (no trailing gap after the last frame).
  - Else if `gap_cfg`=0, go to S1A (back-to-back frames).
  - Else load the gap counter with `gap_cfg` and go to GAP.
- GAP on transfer: decrement the gap counter; when it was 1, go to S1A.
- DONE: unconditionally go to IDLE next edge.
- `start` is ignored in every state except IDLE, including DONE.
- Counters never wrap: `frames_left` is only decremented from a nonzero value, and the gap counter is only loaded with a nonzero value.
- Maximum burst is 2^CNT_W-1 frames; maximum gap is 2^GAP_W-1 bits.

## Timing
- Reset: with `reset`=0 at a rising edge, the FSM goes to IDLE and all counters clear.
  - All outputs are 0 in the following cycle.
  - Reset asserted mid-burst aborts the burst with no `done` pulse.
  - Reset has priority over `start`.
- Start latency: `start` sampled at the edge closing cycle k gives `busy`=1 and `out_valid`=1 with `out_bit`=1 in cycle k+1.
- Throughput: with `out_ready` held 1, one bit per cycle.
  - Burst length in bits = 4·N + (N-1)·G, where N = `num_frames` and G = `gap_len`.
  - `done` asserts in cycle k+1+bits, and `busy` falls the cycle after that.
- `num_frames`=0: `done`=1 and `busy`=1 in cycle k+1, IDLE in k+2, `out_valid` never asserts.
- Backpressure: each cycle with `out_ready`=0 while `out_valid`=1 delays every later event by exactly one cycle. `out_bit` and `frame_end` must not change while stalled.
- Earliest next start: a `start` in the cycle after DONE (state IDLE) is accepted.

## Test plan
- **Reset:** drive `reset`=0 for 2 cycles with `start`=1 -> all outputs 0, `start` ignored; release -> still IDLE.
- **Single frame:** N=1, G=3, `out_ready`=1, `start` in cycle k -> `out_bit` 1,0,0,1 in cycles k+1..k+4, `frame_end` only in k+4, no gap bits, `done` in k+5, `busy` high k+1..k+5.
- **Multi-frame with gaps:** N=3, G=2 -> 16-bit stream 1001 00 1001 00 1001, `frame_end` in k+4, k+10 and k+16, `done` in k+17. `start` pulsed at k+6 is ignored.
- **Back-to-back frames:** N=2, G=0 -> 10011001 in k+1..k+8, `done` in k+9.
- **Backpressure:** N=2, G=1, `out_ready` low in cycles k+2, k+3 and k+7 -> bit sequence identical to the unstalled 100101001, outputs frozen during stalls, `done` in k+13.
- **Edge cases:**
  - N=0 -> `done` in k+1, `out_valid` never high.
  - N=2, G=1 with `reset`=0 driven in cycle k+3 -> all outputs 0 from k+4, no `done`.
  - A new `start` right after DONE -> accepted, burst repeats correctly.
